// File: rtl/mem_access_ctrl_pkg.sv
// Shared FSM state type and default sizing for the memory access controller.
package mem_ctrl_pkg;
  localparam int DEF_ADDR_W        = 5;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_STROBE_CYCLES = 2;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  // The clear sweep visits every index exactly once, so its counter spans the index width.
  function automatic int clr_cnt_width(input int addr_w);
    return addr_w;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the datapath and the memory access controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DEF_DATA_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_strobe_timer.sv
// Loadable down-counter that flags the final cycle of a memory strobe.
module mem_strobe_timer #(
  parameter int CYCLES = mem_ctrl_pkg::DEF_STROBE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("mem_strobe_timer: CYCLES must be at least 1");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// Synchronous initiator for the level-sensitive async register memory.
// Optional full-array clear sweep is built when MEM_CLEAR_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request (or a clear start)
// SETUP  | index/data driven, strobes low
// STROBE | R_B or w_B high for STROBE_CYCLES cycles
// HOLD   | strobes low, index/data still held
// RESP   | response presented until rsp_ready
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus,
  output logic               busy,
  output logic [ADDR_W-1:0]  mem_index,
  output logic               mem_r_b,
  output logic               mem_w_b,
  output logic [DATA_W-1:0]  mem_data,
`ifdef MEM_CLEAR_EN
  input  logic               clr_start,
  output logic               clr_done,
`endif
  input  logic [DATA_W-1:0]  mem_data_out
);
  state_t            state, state_nxt;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              strobe_last;
  logic              ready_int;
  logic              accept;
  logic              clr_go;
  logic              clr_q;
  logic              clr_last;

`ifdef MEM_CLEAR_EN
  localparam int CLR_W = clr_cnt_width(ADDR_W);
  logic [CLR_W-1:0] clr_addr;

  assign clr_go    = (state == IDLE) && clr_start;
  assign clr_last  = (clr_addr == '1);
  assign ready_int = (state == IDLE) && !rst && !clr_start;
`else
  assign clr_go    = 1'b0;
  assign clr_q     = 1'b0;
  assign clr_last  = 1'b0;
  assign ready_int = (state == IDLE) && !rst;
`endif

  assign accept = bus.req_valid && ready_int;

  mem_strobe_timer #(.CYCLES(STROBE_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == SETUP),
    .en   (state == STROBE),
    .last (strobe_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr_go || accept) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (strobe_last) state_nxt = HOLD;
      HOLD:    if (clr_q) state_nxt = clr_last ? IDLE : SETUP;
               else       state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    mem_r_b = (state == STROBE) && !we_q;
    mem_w_b = (state == STROBE) && we_q;
  end

  assign bus.req_ready = ready_int;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_we    = (state == RESP) && we_q;
  assign bus.rsp_rdata = rdata_q;

  // Index/data only ever load in IDLE or HOLD, so they cannot move under a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      mem_index <= '0;
      mem_data  <= '0;
      rdata_q   <= '0;
`ifdef MEM_CLEAR_EN
      clr_q     <= 1'b0;
      clr_addr  <= '0;
      clr_done  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q      <= bus.req_we;
        mem_index <= bus.req_addr;
        mem_data  <= bus.req_we ? bus.req_wdata : '0;
      end
      if ((state == STROBE) && strobe_last && !we_q) rdata_q <= mem_data_out;
`ifdef MEM_CLEAR_EN
      clr_done <= 1'b0;
      if (clr_go) begin
        clr_q     <= 1'b1;
        we_q      <= 1'b1;
        clr_addr  <= '0;
        mem_index <= '0;
        mem_data  <= '0;
      end
      if ((state == HOLD) && clr_q) begin
        if (clr_last) begin
          clr_q    <= 1'b0;
          we_q     <= 1'b0;
          clr_done <= 1'b1;
        end else begin
          clr_addr  <= clr_addr + 1'b1;
          mem_index <= clr_addr + 1'b1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural async register memory.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          busy, mem_r_b, mem_w_b;
  logic [AW-1:0] mem_index;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_data_out = '0;
`ifdef MEM_CLEAR_EN
  logic clr_start = 1'b0;
  logic clr_done;
`endif

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .mem_index    (mem_index),
    .mem_r_b      (mem_r_b),
    .mem_w_b      (mem_w_b),
    .mem_data     (mem_data),
`ifdef MEM_CLEAR_EN
    .clr_start    (clr_start),
    .clr_done     (clr_done),
`endif
    .mem_data_out (mem_data_out)
  );

  // Level-sensitive memory: writes while w_B high, DATA_OUT follows while R_B high, else holds.
  logic [DW-1:0] mem_model [32] = '{default: '0};
  always @(negedge clk) begin
    if (mem_w_b) mem_model[mem_index] <= mem_data;
    if (mem_r_b) mem_data_out <= mem_model[mem_index];
  end

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    int            t_exp;
    string         name;
  } exp_t;
  exp_t sb_q[$];

  logic          prev_valid = 1'b0;
  logic [DW-1:0] held_rdata = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_valid) begin
        chk("rsp_expected", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          chk({sb_q[0].name, "_latency"}, 64'(cyc), 64'(sb_q[0].t_exp));
          chk({sb_q[0].name, "_rsp_we"}, 64'(bus.rsp_we), 64'(sb_q[0].we));
          chk({sb_q[0].name, "_rdata"}, 64'(bus.rsp_rdata), 64'(sb_q[0].rdata));
        end
        held_rdata = bus.rsp_rdata;
      end else if (bus.rsp_valid) begin
        chk("rdata_stable", 64'(bus.rsp_rdata), 64'(held_rdata));
        chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
      end else if (sb_q.size() > 0 && cyc > sb_q[0].t_exp) begin
        chk({sb_q[0].name, "_rsp_present"}, 64'(bus.rsp_valid), 64'd1);
        void'(sb_q.pop_front());
      end
      if (bus.rsp_valid && bus.rsp_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      prev_valid = bus.rsp_valid;
    end
  end

  // Protocol monitor: exclusive strobes, exact strobe width, index/data frozen around strobes.
  int            run_len  = 0;
  logic          strb_now = 1'b0;
  logic          p_strobe = 1'b0;
  logic [AW-1:0] p_idx    = '0;
  logic [DW-1:0] p_dat    = '0;
  always @(negedge clk) begin
    strb_now = mem_r_b | mem_w_b;
    if (rst) begin
      run_len  = 0;
      strb_now = 1'b0;
    end else begin
      if (strb_now) chk("strobe_exclusive", 64'(mem_r_b & mem_w_b), 64'd0);
      if (strb_now || p_strobe) begin
        chk("index_stable", 64'(mem_index), 64'(p_idx));
        chk("data_stable", 64'(mem_data), 64'(p_dat));
      end
      if (strb_now) run_len++;
      else if (p_strobe) begin
        chk("strobe_len", 64'(run_len), 64'(SC));
        run_len = 0;
      end
    end
    p_strobe = strb_now;
    p_idx    = mem_index;
    p_dat    = mem_data;
  end

  logic [DW-1:0] shadow [32] = '{default: '0};
  logic [DW-1:0] last_rd = '0;

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rd, input string name, input bit push);
    int n = 0;
    @(posedge clk); #2;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    if (bus.req_ready) begin
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      if (push) sb_q.push_back('{we, exp_rd, cyc + 3 + SC, name});
      @(posedge clk); #2;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string name);
    do_req(1'b1, addr, data, last_rd, name, 1'b1);
    shadow[addr] = data;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    do_req(1'b0, addr, '0, exp, name, 1'b1);
    last_rd = exp;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({name, "_rsp_we"}, 64'(bus.rsp_we), 64'd0);
    chk({name, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_mem_index"}, 64'(mem_index), 64'd0);
    chk({name, "_mem_data"}, 64'(mem_data), 64'd0);
    chk({name, "_strobes"}, 64'({mem_r_b, mem_w_b}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("reset_release_ready", 64'(bus.req_ready), 64'd1);

    wr(5'd5, 32'hDEAD_BEEF, "wr5");
    rd(5'd5, 32'hDEAD_BEEF, "rd5");
    drain("basic");

    wr(5'd31, 32'hFFFF_FFFF, "wr31");
    wr(5'd0, 32'h0000_0001, "wr0");
    rd(5'd31, 32'hFFFF_FFFF, "rd31");
    rd(5'd0, 32'h0000_0001, "rd0");
    drain("bounds");

    wr(5'd3, 32'hA5A5_0003, "wr3");
    drain("bp_pre");
    bus.rsp_ready = 1'b0;
    rd(5'd3, 32'hA5A5_0003, "bp_rd3");
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0003);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_release_idle", 64'(bus.req_ready), 64'd1);
    drain("bp");

    for (int i = 0; i < 200; i++) begin
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 31));
      d  = $urandom;
      if (we) wr(a, d, "rnd_wr");
      else    rd(a, shadow[a], "rnd_rd");
    end
    drain("random");

    do_req(1'b1, 5'd7, 32'h7777_7777, '0, "rst_wr7", 1'b0);
    n = 0;
    while (!mem_w_b && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rst_reached_strobe", 64'(mem_w_b), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_all_zero("midop_reset");
    rst = 1'b0;
    last_rd = '0;
    #1;
    chk("midop_release_ready", 64'(bus.req_ready), 64'd1);
    rd(5'd2, shadow[2], "post_rst_rd2");
    drain("post_rst");

`ifdef MEM_CLEAR_EN
    begin
      int c0;
      wr(5'd9, 32'h0000_1234, "clr_wr9");
      drain("clr_pre");
      @(posedge clk); #2;
      clr_start     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd4;
      bus.req_wdata = 32'h0000_0BAD;
      #1;
      chk("clr_blocks_req", 64'(bus.req_ready), 64'd0);
      c0 = cyc;
      @(posedge clk); #2;
      clr_start     = 1'b0;
      bus.req_valid = 1'b0;
      n = 0;
      while (!clr_done && n < 300) begin
        @(posedge clk); #2;
        n++;
      end
      chk("clr_done_seen", 64'(clr_done), 64'd1);
      chk("clr_done_time", 64'(cyc), 64'(c0 + 128));
      for (int i = 0; i < 32; i++) shadow[i] = '0;
      rd(5'd9, 32'h0, "clr_rd9");
      rd(5'd4, 32'h0, "clr_rd4");
      drain("clr");
    end
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Synchronous initiator for the 32x32 level-sensitive asynchronous register memory (index, R_B, w_B, DATA, DATA_OUT port).
- Accepts single read/write requests from the datapath over a valid/ready handshake.
- Sequences the memory's level-sensitive strobes safely (address/data stable before, during and after each strobe) and returns read data over a valid/ready response channel.
- Sits between the datapath control unit and the memory instance.

Parameters:
- ADDR_W, 5, memory index width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data word width.
- STROBE_CYCLES, 2, cycles R_B/w_B are held high; must be >=1, and 0 fails at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target index.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_we  out  1  echo of the accepted req_we.
- rsp_rdata  out  DATA_W  read result.
- busy  out  1  high in every state except IDLE.
- mem_index  out  ADDR_W  drives memory index.
- mem_r_b  out  1  drives memory R_B.
- mem_w_b  out  1  drives memory w_B.
- mem_data  out  DATA_W  drives memory DATA.
- mem_data_out  in  DATA_W  from memory DATA_OUT.

Behaviour:
- Reset: state IDLE; all outputs 0 while rst is sampled high. req_ready rises in the first cycle after rst is released.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready: latch we/addr/wdata and go to SETUP.
- SETUP (1 cycle)
  - mem_index=addr; mem_data=wdata for writes, 0 for reads.
  - Both strobes 0.
- STROBE (STROBE_CYCLES cycles, down-counter)
  - mem_w_b=we, mem_r_b=!we.
  - On a read, capture mem_data_out into rsp_rdata on the last STROBE cycle.
- HOLD (1 cycle)
  - Both strobes 0; index and data still held.
- RESP
  - rsp_valid=1, rsp_we=latched we.
  - Hold until rsp_ready, then go to IDLE.
  - rsp_rdata is stable while rsp_valid=1. Writes leave rsp_rdata unchanged.
- Latency: handshake at cycle T gives rsp_valid at T+3+STROBE_CYCLES (T+5 at default). Throughput is one transaction per 4+STROBE_CYCLES cycles when rsp_ready=1.
- Invariants:
  - mem_r_b and mem_w_b are never both 1.
  - Both strobes are 0 outside STROBE.
  - mem_index and mem_data never change while either strobe is 1.
  - mem_index and mem_data are registered outputs.
- Request inputs are ignored while req_ready=0.
- Reset mid-operation: at the next edge everything returns to reset values. The transaction is dropped and no response is produced. A write interrupted during STROBE may have partially updated that one location; this is acceptable.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined, ports added:
  - clr_start  in  1
  - clr_done  out  1
- Clear trigger: clr_start in IDLE starts a clear sequence that writes 0 to addresses 0..DEPTH-1 using SETUP/STROBE/HOLD with no RESP.
- Completion: after the last address, clr_done pulses for 1 cycle and the FSM returns to IDLE.
- Duration: DEPTH*(2+STROBE_CYCLES) cycles (128 at defaults).
- Priority: clr_start beats req_valid; req_ready = (state==IDLE) && !clr_start.
- busy=1 throughout the clear.
- Undefined: the ports and clear logic are absent, and behaviour is exactly as above.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - default ADDR_W/DATA_W/STROBE_CYCLES constants;
  - the clear-address counter width.
- Sub-module mem_strobe_timer: loadable down-counter that flags the last STROBE cycle. It is reused by the clear sequence.

Test Plan:
- The bench uses a behavioural model of the asynchronous memory, which holds the last DATA_OUT while R_B is low.
- Write: 0xDEADBEEF to addr 5, then read addr 5 -> each rsp_valid at T+5; read gives rsp_rdata=0xDEADBEEF, rsp_we=0.
- Protocol monitor over 200 random transactions: strobes are never both high, each strobe lasts exactly 2 cycles, and mem_index/mem_data are stable for the SETUP..HOLD window.
- Backpressure: rsp_ready=0 for 10 cycles on a read of addr 3 -> rsp_valid stays 1, rsp_rdata stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
- Boundaries: write 0xFFFFFFFF to addr 31 and 0x00000001 to addr 0, then read both -> exact values, no aliasing.
- Reset during STROBE of a write to addr 7 -> the following cycle has all outputs 0, no rsp_valid; a subsequent read of addr 2 completes normally.
- MEM_CLEAR_EN:
  - Write 0x1234 to addr 9, then clr_start -> clr_done after 128 cycles; reading addr 9 returns 0.
  - clr_start and req_valid in the same cycle -> request not accepted.
